// File: rtl/mem_access_unit.sv
// Memory-side stage behind the multicycle control FSM: req/ack handshake to a
// variable-latency memory, IR/MDR holding, stall generation. Optional MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_req,
    input  logic              i_or_d,
    input  logic              ir_write,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] write_data,
    output logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic       fetch;

    // DONE is the single cycle in which the FSM is allowed to advance
    assign stall  = acc_req && (state != DONE);
    assign opcode = instr[31:26];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             timeout;

    // ack on the final allowed cycle wins over the timeout
    assign timeout = !mem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            if (state == IDLE)
                cnt <= '0;
            else if (state == BUSY && !mem_ack)
                cnt <= cnt + 1'b1;
            if (state == BUSY && timeout)
                bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            fetch     <= 1'b0;
            instr     <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_req) begin
                        mem_addr  <= i_or_d ? alu_out : pc;
                        mem_we    <= mem_write;
                        mem_wdata <= write_data;
                        fetch     <= ir_write;
                        mem_req   <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                        if (!mem_we) begin
                            mdr <= mem_rdata;
                            if (fetch)
                                instr <= mem_rdata;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timeout) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven, scoreboarded bench for mem_access_unit; timeout vectors are
// added when MEM_TIMEOUT_EN is defined (instance uses TIMEOUT_CYCLES=4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        acc_req, i_or_d, ir_write, mem_write;
    logic [31:0] pc, alu_out, write_data;
    logic        stall;
    logic [31:0] instr, mdr, mem_addr, mem_wdata, mem_rdata;
    logic [5:0]  opcode;
    logic        mem_req, mem_we, mem_ack, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        iod, irw, mw;
        logic [31:0] pc, alu, wd, rdata;
        int          waits;
        logic [31:0] exp_addr, exp_mdr, exp_instr;
        int          exp_stall, exp_req;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .acc_req(acc_req), .i_or_d(i_or_d),
        .ir_write(ir_write), .mem_write(mem_write), .pc(pc), .alu_out(alu_out),
        .write_data(write_data), .stall(stall), .instr(instr), .opcode(opcode),
        .mdr(mdr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v);
        int   stall_cnt = 0;
        int   req_cnt = 0;
        bit   done = 0;
        vec_t e;
        sb.push_back(v);
        @(negedge clk);
        acc_req = 1'b1; i_or_d = v.iod; ir_write = v.irw; mem_write = v.mw;
        pc = v.pc; alu_out = v.alu; write_data = v.wd; mem_ack = 1'b0;
        #1;
        check("idle_gap_req", {31'd0, mem_req}, 32'd0);
        for (int c = 0; c < 300 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                mem_ack = 1'b0;
                #1;
            end
            if (mem_req) begin
                check("req_addr", mem_addr, v.exp_addr);
                check("req_we", {31'd0, mem_we}, {31'd0, v.mw});
                check("req_wdata", mem_wdata, v.wd);
                if (req_cnt == v.waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
                req_cnt++;
            end else begin
                check("we_without_req", {31'd0, mem_we}, 32'd0);
            end
            if (stall) begin
                stall_cnt++;
            end else begin
                done = 1;
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard_empty: got 0 entries expected 1");
                end else begin
                    e = sb.pop_front();
                    check("stall_cycles", stall_cnt, e.exp_stall);
                    check("req_cycles", req_cnt, e.exp_req);
                    check("mdr", mdr, e.exp_mdr);
                    check("instr", instr, e.exp_instr);
                    check("opcode", {26'd0, opcode}, {26'd0, e.exp_instr[31:26]});
                    check("bus_err", {31'd0, bus_err}, {31'd0, e.exp_err});
                    mem_ack   = 1'b1;      // spurious ack while in DONE
                    mem_rdata = ~e.rdata;
                end
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL access_timeout: got stall still high expected completion within 300 cycles");
        end
        @(negedge clk);
        mem_ack = 1'b0;
        acc_req = 1'b0;
        #1;
        check("post_done_mdr", mdr, v.exp_mdr);
        check("post_done_instr", instr, v.exp_instr);
        check("post_done_req", {31'd0, mem_req}, 32'd0);
        check("post_done_stall", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        int n_vec;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h4,   32'h0,   32'h0,        32'h8C080010, 0,    32'h4,   32'h8C080010, 32'h8C080010, 2, 1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h4,   32'h10,  32'h0,        32'hDEADBEEF, 3,    32'h10,  32'hDEADBEEF, 32'h8C080010, 5, 4, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h8,   32'h20,  32'h12345678, 32'hFFFFFFFF, 2,    32'h20,  32'hDEADBEEF, 32'h8C080010, 4, 3, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h20,  32'hAAAA5555, 32'hAC0A0004, 1,    32'h100, 32'hAC0A0004, 32'hAC0A0004, 3, 2, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h200, 32'h300, 32'h0,        32'h0BADF00D, 0,    32'h200, 32'h0BADF00D, 32'hAC0A0004, 2, 1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h8,   32'h0,   32'h0,        32'h2008FFFF, 0,    32'h8,   32'h2008FFFF, 32'h2008FFFF, 2, 1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h8,   32'h44,  32'h0,        32'h13579BDF, 3,    32'h44,  32'h13579BDF, 32'h2008FFFF, 5, 4, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h8,   32'h48,  32'h0,        32'h55555555, 1000, 32'h48,  32'h13579BDF, 32'h2008FFFF, 5, 4, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'hC,   32'h0,   32'h0,        32'h24420001, 0,    32'hC,   32'h24420001, 32'h24420001, 2, 1, 1'b1};
`ifdef MEM_TIMEOUT_EN
        n_vec = 9;
`else
        n_vec = 7;
`endif
        reset = 1'b1; acc_req = 1'b0; i_or_d = 1'b0; ir_write = 1'b0; mem_write = 1'b0;
        pc = '0; alu_out = '0; write_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_instr", instr, 32'd0);
        check("rst_mdr", mdr, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_err", {31'd0, bus_err}, 32'd0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 5; i++)
            run_access(vecs[i]);

        // spurious ack while idle must not disturb anything
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("idle_ack_mdr", mdr, 32'h0BADF00D);
        check("idle_ack_instr", instr, 32'hAC0A0004);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);

        // reset in the middle of a transfer
        @(negedge clk);
        acc_req = 1'b1; i_or_d = 1'b0; ir_write = 1'b1; mem_write = 1'b0; pc = 32'h40;
        @(negedge clk);
        #1;
        check("mid_req_before_rst", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_instr", instr, 32'd0);
        check("mid_rst_mdr", mdr, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        acc_req = 1'b0;

        for (int i = 5; i < n_vec; i++)
            run_access(vecs[i]);

        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
